// File: rtl/event_packetizer_pkg.sv
// Shared defaults and the AER event word layout for the EBC readout packetizer.
package event_packetizer_pkg;

    localparam int unsigned AddrWDef = 3;
    localparam int unsigned TsWDef   = 16;

    typedef struct packed {
        logic                last;
        logic                polarity;
        logic [AddrWDef-1:0] x;
        logic [AddrWDef-1:0] y;
        logic [TsWDef-1:0]   ts;
    } event_t;

    localparam int unsigned EventWDef = $bits(event_t);

    function automatic int unsigned event_width(int unsigned addr_w, int unsigned ts_w);
        return 2 + 2 * addr_w + ts_w;
    endfunction

endpackage

// File: rtl/event_packetizer_if.sv
// Arbiter-side grant inputs and consumer-side event stream of the packetizer.
interface event_packetizer_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned EventW = 2 + 2 * ADDR_W + TS_W;
    localparam int unsigned LevelW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]  y_gnt_i;
    logic [ADDR_W-1:0] yadd_i;
    logic [ADDR_W-1:0] xadd_i;
    logic              polarity_i;
    logic              grp_release_i;
    logic              arb_enable_o;
    logic [EventW-1:0] event_o;
    logic              event_valid_o;
    logic              event_ready_i;
    logic [7:0]        drop_cnt_o;
    logic [LevelW-1:0] fifo_level_o;

    // Packetizer side.
    modport slave (
        input  y_gnt_i, yadd_i, xadd_i, polarity_i, grp_release_i, event_ready_i,
        output arb_enable_o, event_o, event_valid_o, drop_cnt_o, fifo_level_o
    );

    // Arbiter/consumer side.
    modport master (
        output y_gnt_i, yadd_i, xadd_i, polarity_i, grp_release_i, event_ready_i,
        input  arb_enable_o, event_o, event_valid_o, drop_cnt_o, fifo_level_o
    );

endinterface

// File: rtl/event_packetizer_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so level == DEPTH means full.
module event_packetizer_sync_fifo #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW:0]     wptr_q, wptr_d;
    logic [PtrW:0]     rptr_q, rptr_d;
    logic              push_ok, pop_ok;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == (PtrW + 1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[PtrW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/event_packetizer.sv
// Timestamps arbiter grants into AER event words, buffers them, and throttles the arbiters
// from buffer occupancy; events arriving on a full buffer are counted as drops.
module event_packetizer
    import event_packetizer_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = AddrWDef,
    parameter int unsigned TS_W   = TsWDef,
    parameter int unsigned DEPTH  = 8
) (
    input logic                clk_i,
    input logic                reset_i,
    event_packetizer_if.slave  bus
);
    localparam int unsigned EventW = event_width(ADDR_W, TS_W);
    localparam int unsigned LevelW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              last;
        logic              polarity;
        logic [ADDR_W-1:0] x;
        logic [ADDR_W-1:0] y;
        logic [TS_W-1:0]   ts;
    } word_t;

    logic [WIDTH-1:0]  gnt;
    logic              ev_present, push, pop, full, empty, drop;
    logic [LevelW-1:0] level, level_next;
    logic [EventW-1:0] rdata;
    word_t             wdata;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [7:0]        drop_q, drop_d;
    logic              en_q, en_d;

    // Multi-hot grants still count as a single event; yadd_i carries the address.
    assign gnt        = bus.y_gnt_i;
    assign ev_present = |gnt;
    assign pop        = !empty && bus.event_ready_i;
    assign push       = ev_present && (!full || pop);
    assign drop       = ev_present && full && !pop;

    always_comb begin
        wdata.last     = bus.grp_release_i;
        wdata.polarity = bus.polarity_i;
        wdata.x        = bus.xadd_i;
        wdata.y        = bus.yadd_i;
        wdata.ts       = ts_q;
    end

    always_comb begin
        level_next = level + LevelW'(push) - LevelW'(pop);
        ts_d       = ts_q + 1'b1;
        drop_d     = drop_q;
        if (drop && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
        // Two cycles of headroom: one for this register, one for the arbiter grant register.
        en_d       = (level_next <= LevelW'(DEPTH - 3));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q   <= '0;
            drop_q <= '0;
            en_q   <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            drop_q <= drop_d;
            en_q   <= en_d;
        end
    end

    event_packetizer_sync_fifo #(
        .DATA_W (EventW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.event_o       = rdata;
    assign bus.event_valid_o = !empty;
    assign bus.fifo_level_o  = level;
    assign bus.drop_cnt_o    = drop_q;
    assign bus.arb_enable_o  = en_q;

endmodule

// File: tb/tb_event_packetizer.sv
// Directed bench for event_packetizer: default DUT plus a TS_W=4 instance for timestamp wrap.
module tb_event_packetizer;
    import event_packetizer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    event_packetizer_if #(.WIDTH(8), .ADDR_W(3), .TS_W(16), .DEPTH(8)) bus ();
    event_packetizer_if #(.WIDTH(8), .ADDR_W(3), .TS_W(4), .DEPTH(8)) bus4 ();

    event_packetizer #(.WIDTH(8), .ADDR_W(3), .TS_W(16), .DEPTH(8)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    event_packetizer #(.WIDTH(8), .ADDR_W(3), .TS_W(4), .DEPTH(8)) dut4 (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus4)
    );

    function automatic logic [EventWDef-1:0] mk(input logic last, input logic pol,
                                                input logic [2:0] x, input logic [2:0] y,
                                                input logic [15:0] ts);
        event_t e;
        e.last = last; e.polarity = pol; e.x = x; e.y = y; e.ts = ts;
        return e;
    endfunction

    // Expected word for indexed event i captured at timestamp i.
    function automatic logic [EventWDef-1:0] exp_evt(input int i);
        logic [15:0] v;
        v = 16'(i);
        return mk(v[1], v[0], v[2:0], ~v[2:0], v);
    endfunction

    task automatic idle();
        bus.y_gnt_i = '0; bus.yadd_i = '0; bus.xadd_i = '0;
        bus.polarity_i = 1'b0; bus.grp_release_i = 1'b0; bus.event_ready_i = 1'b0;
        bus4.y_gnt_i = '0; bus4.yadd_i = '0; bus4.xadd_i = '0;
        bus4.polarity_i = 1'b0; bus4.grp_release_i = 1'b0; bus4.event_ready_i = 1'b0;
    endtask

    task automatic drive_evt(input int i);
        logic [15:0] v;
        logic [7:0]  one;
        v = 16'(i);
        one = 8'd1;
        bus.yadd_i = ~v[2:0];
        bus.y_gnt_i = one << bus.yadd_i;
        bus.xadd_i = v[2:0];
        bus.polarity_i = v[0];
        bus.grp_release_i = v[1];
    endtask

    // Leaves the bench at a falling edge with ts = 0 and reset released.
    task automatic do_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.event_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.event_valid_o); end
        checks++; if (bus.event_o !== '0) begin errors++; $display("FAIL reset_event got %h want 0", bus.event_o); end
        checks++; if (bus.fifo_level_o !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level_o); end
        checks++; if (bus.drop_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", bus.drop_cnt_o); end
        checks++; if (bus.arb_enable_o !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", bus.arb_enable_o); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.arb_enable_o !== 1'b1) begin errors++; $display("FAIL reset_en_rise got %0b want 1", bus.arb_enable_o); end
    endtask

    task automatic test_single_event();
        do_reset();
        repeat (10) @(negedge clk);
        bus.y_gnt_i = 8'b0000_0100; bus.yadd_i = 3'd2; bus.xadd_i = 3'd5;
        bus.polarity_i = 1'b1; bus.grp_release_i = 1'b0;
        @(negedge clk);
        idle();
        checks++; if (bus.event_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.event_valid_o); end
        checks++; if (bus.event_o !== mk(1'b0, 1'b1, 3'd5, 3'd2, 16'd10)) begin errors++; $display("FAIL single_word got %h want %h", bus.event_o, mk(1'b0, 1'b1, 3'd5, 3'd2, 16'd10)); end
        checks++; if (bus.fifo_level_o !== 4'd1) begin errors++; $display("FAIL single_level got %0d want 1", bus.fifo_level_o); end
        @(negedge clk);
        checks++; if (bus.event_o !== mk(1'b0, 1'b1, 3'd5, 3'd2, 16'd10)) begin errors++; $display("FAIL single_hold got %h", bus.event_o); end
    endtask

    // Arbiter modelled as two register stages between arb_enable_o and a grant.
    task automatic test_back_pressure();
        logic p1, p2, en5, en6;
        int peak;
        do_reset();
        p1 = 1'b0; p2 = 1'b0; en5 = 1'bx; en6 = 1'bx; peak = 0;
        for (int k = 0; k < 20; k++) begin
            if (int'(bus.fifo_level_o) > peak) peak = int'(bus.fifo_level_o);
            if (bus.fifo_level_o == 4'd5) en5 = bus.arb_enable_o;
            if (bus.fifo_level_o == 4'd6 && en6 === 1'bx) en6 = bus.arb_enable_o;
            if (p2) drive_evt(k); else bus.y_gnt_i = '0;
            p2 = p1;
            p1 = bus.arb_enable_o;
            @(negedge clk);
        end
        idle();
        checks++; if (en5 !== 1'b1) begin errors++; $display("FAIL bp_en_at5 got %0b want 1", en5); end
        checks++; if (en6 !== 1'b0) begin errors++; $display("FAIL bp_en_at6 got %0b want 0", en6); end
        checks++; if (peak != 8) begin errors++; $display("FAIL bp_peak got %0d want 8", peak); end
        checks++; if (bus.drop_cnt_o !== 8'd0) begin errors++; $display("FAIL bp_drop got %0d want 0", bus.drop_cnt_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive_evt(i);
            @(negedge clk);
        end
        idle();
        checks++; if (bus.fifo_level_o !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d want 8", bus.fifo_level_o); end
        checks++; if (bus.drop_cnt_o !== 8'd4) begin errors++; $display("FAIL ovf_drop got %0d want 4", bus.drop_cnt_o); end
        checks++; if (bus.arb_enable_o !== 1'b0) begin errors++; $display("FAIL ovf_en got %0b want 0", bus.arb_enable_o); end
        bus.event_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.event_valid_o !== 1'b1 || bus.event_o !== exp_evt(i)) begin errors++; $display("FAIL ovf_drain%0d got %b/%h want 1/%h", i, bus.event_valid_o, bus.event_o, exp_evt(i)); end
            @(negedge clk);
        end
        idle();
        checks++; if (bus.event_valid_o !== 1'b0 || bus.fifo_level_o !== 4'd0) begin errors++; $display("FAIL ovf_empty got valid %0b level %0d want 0 0", bus.event_valid_o, bus.fifo_level_o); end
        checks++; if (bus.arb_enable_o !== 1'b1) begin errors++; $display("FAIL ovf_en_back got %0b want 1", bus.arb_enable_o); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_evt(i);
            @(negedge clk);
        end
        drive_evt(8);
        bus.event_ready_i = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (bus.fifo_level_o !== 4'd8) begin errors++; $display("FAIL fpp_level got %0d want 8", bus.fifo_level_o); end
        checks++; if (bus.drop_cnt_o !== 8'd0) begin errors++; $display("FAIL fpp_drop got %0d want 0", bus.drop_cnt_o); end
        bus.event_ready_i = 1'b1;
        for (int i = 1; i < 9; i++) begin
            checks++; if (bus.event_o !== exp_evt(i)) begin errors++; $display("FAIL fpp_drain%0d got %h want %h", i, bus.event_o, exp_evt(i)); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_ts_wrap();
        do_reset();
        repeat (15) @(negedge clk);
        bus4.y_gnt_i = 8'b0001_0000; bus4.yadd_i = 3'd4; bus4.xadd_i = 3'd3;
        bus4.polarity_i = 1'b0; bus4.grp_release_i = 1'b1;
        @(negedge clk);
        bus4.y_gnt_i = 8'b0000_0010; bus4.yadd_i = 3'd1; bus4.xadd_i = 3'd6;
        bus4.polarity_i = 1'b1; bus4.grp_release_i = 1'b0;
        @(negedge clk);
        idle();
        checks++; if (bus4.fifo_level_o !== 4'd2) begin errors++; $display("FAIL wrap_level got %0d want 2", bus4.fifo_level_o); end
        checks++; if (bus4.event_o !== {1'b1, 1'b0, 3'd3, 3'd4, 4'd15}) begin errors++; $display("FAIL wrap_first got %h want %h", bus4.event_o, {1'b1, 1'b0, 3'd3, 3'd4, 4'd15}); end
        bus4.event_ready_i = 1'b1;
        @(negedge clk);
        bus4.event_ready_i = 1'b0;
        checks++; if (bus4.event_o !== {1'b0, 1'b1, 3'd6, 3'd1, 4'd0}) begin errors++; $display("FAIL wrap_second got %h want %h", bus4.event_o, {1'b0, 1'b1, 3'd6, 3'd1, 4'd0}); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_evt(i);
            @(negedge clk);
        end
        idle();
        bus.event_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.fifo_level_o !== 4'd5 || bus.drop_cnt_o !== 8'd2) begin errors++; $display("FAIL mid_pre got level %0d drop %0d want 5 2", bus.fifo_level_o, bus.drop_cnt_o); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.event_valid_o !== 1'b0 || bus.fifo_level_o !== 4'd0) begin errors++; $display("FAIL mid_async got valid %0b level %0d want 0 0", bus.event_valid_o, bus.fifo_level_o); end
        checks++; if (bus.drop_cnt_o !== 8'd0 || bus.arb_enable_o !== 1'b0) begin errors++; $display("FAIL mid_async2 got drop %0d en %0b want 0 0", bus.drop_cnt_o, bus.arb_enable_o); end
        idle();
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.arb_enable_o !== 1'b0) begin errors++; $display("FAIL mid_en_early got %0b want 0", bus.arb_enable_o); end
        @(negedge clk);
        checks++; if (bus.arb_enable_o !== 1'b1) begin errors++; $display("FAIL mid_en_rise got %0b want 1", bus.arb_enable_o); end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        for (int i = 0; i < 270; i++) begin
            drive_evt(i);
            @(negedge clk);
        end
        idle();
        checks++; if (bus.drop_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d want 255", bus.drop_cnt_o); end
        checks++; if (bus.fifo_level_o !== 4'd8) begin errors++; $display("FAIL sat_level got %0d want 8", bus.fifo_level_o); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_event();
        test_back_pressure();
        test_overflow();
        test_full_push_pop();
        test_ts_wrap();
        test_reset_mid_burst();
        test_drop_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_packetizer.md
# event_packetizer

Downstream of the row/column round-robin arbiters in the EBC readout path. Each cycle the column arbiter presents a one-hot grant with the matching row (x) and column (y) addresses, this block stamps it with a free-running timestamp, packs it into an AER event word and buffers it in a small FIFO drained by a valid/ready consumer. It drives the arbiters' enable from FIFO occupancy so grants stall before the buffer can overflow, and counts any event that still arrives when the FIFO is full.

## Interface
- WIDTH, 8: width of the column grant vector.
- ADDR_W, 3: width of x and y addresses (log2 WIDTH).
- TS_W, 16: timestamp width.
- DEPTH, 8: FIFO entries (power of two, ≥4).
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- y_gnt_i  in  WIDTH  registered one-hot grant from the column arbiter; nonzero = event present.
- yadd_i  in  ADDR_W  column address accompanying y_gnt_i.
- xadd_i  in  ADDR_W  row address of the currently granted row.
- polarity_i  in  1  event polarity (1 = ON, 0 = OFF).
- grp_release_i  in  1  column arbiter group release; marks last event of a row group.
- arb_enable_o  out  1  registered enable to both arbiters.
- event_o  out  2+2·ADDR_W+TS_W  FIFO head: {last, polarity, xadd, yadd, ts}.
- event_valid_o  out  1  FIFO non-empty.
- event_ready_i  in  1  consumer accepts head when high with event_valid_o.
- drop_cnt_o  out  8  saturating count of dropped events.
- fifo_level_o  out  log2(DEPTH)+1  current occupancy.

## Operation
- Event present: |y_gnt_i == 1 in a cycle. Word captured that cycle: last=grp_release_i, polarity_i, xadd_i, yadd_i, ts (current counter value).
- Timestamp: TS_W-bit counter, +1 every cycle, wraps 2^TS_W−1 → 0; free-running regardless of enable or FIFO state.
- Push: event present and (level < DEPTH or pop in same cycle). Full and no pop → event dropped, drop_cnt_o += 1, saturating at 255.
- Pop: event_valid_o && event_ready_i. Head advances at that edge.
- Simultaneous push/pop: level unchanged; on empty FIFO the pushed word appears on event_o the next cycle (pop cannot happen on empty).
- Flow control: arb_enable_o next = (level_next ≤ DEPTH−3). Covers the 1-cycle enable register plus the 1-cycle arbiter grant register; with a stalled consumer no drop occurs.
- Multi-hot y_gnt_i is treated as one event; yadd_i is authoritative.
- Reset (any time, including mid-burst): FIFO emptied, pointers 0, ts=0, drop_cnt_o=0, arb_enable_o=0; arb_enable_o rises the first edge after reset release.

## Timing
- Reset values: event_valid_o=0, event_o=0, fifo_level_o=0, drop_cnt_o=0, arb_enable_o=0.
- Grant in cycle N → push at edge ending N → event_valid_o high in N+1 if FIFO was empty (show-ahead head).
- event_o stable while event_valid_o && !event_ready_i.
- Level change → arb_enable_o reflects it one edge later (registered).
- Wrap: pointers ADDR-wide with one extra bit for full/empty; level = DEPTH is full, not empty.
- Throughput: one push and one pop per cycle.

## Structure
- ebc_pkg: ADDR_W, TS_W defaults, packed struct event_t {last, polarity, x, y, ts}, event width constant.
- Sub-module sync_fifo #(DATA_W, DEPTH): push/pop, show-ahead data, level, full, empty. Packetizer holds timestamp, packing, drop counter, enable register.

## Test plan
- Single event: after reset, y_gnt_i=8'b0000_0100, yadd_i=2, xadd_i=5, polarity_i=1, ts=10 → next cycle event_valid_o=1, event_o={0,1,5,2,10}, level=1.
- Back-pressure: event_ready_i=0, grant every enabled cycle → arb_enable_o falls when level reaches DEPTH−2, level peaks at DEPTH, drop_cnt_o stays 0.
- Forced overflow: ignore arb_enable_o, drive 12 grants with ready=0 → level=8, drop_cnt_o=4; then drain → 8 events in original order.
- Full + simultaneous push/pop: level=8, ready=1 and grant same cycle → new event accepted, level stays 8, no drop.
- Timestamp wrap with TS_W=4: event at ts=15, next at ts=0 → words carry 15 then 0.
- Reset mid-burst: level=5, assert reset_i → event_valid_o=0, level=0, drop_cnt_o=0 immediately; arb_enable_o=1 one edge after release.
